// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Opcode encoding, op-class helpers and iteration counts for muldiv_unit.
// Revision : 1.0  initial release
// ============================================================================
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_MULW   = 4'd4,
        OP_DIV    = 4'd5,
        OP_DIVU   = 4'd6,
        OP_REM    = 4'd7,
        OP_REMU   = 4'd8,
        OP_DIVW   = 4'd9,
        OP_DIVUW  = 4'd10,
        OP_REMW   = 4'd11,
        OP_REMUW  = 4'd12
    } muldiv_op_t;

    localparam int unsigned WORD_BITS = 32;

    function automatic logic is_div(input muldiv_op_t op);
        return op inside {[OP_DIV:OP_REMUW]};
    endfunction

    function automatic logic is_rem(input muldiv_op_t op);
        return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_word(input muldiv_op_t op);
        return op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_mul_high(input muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    // Signedness of rs1; rs2 is signed for the same ops except MULHSU.
    function automatic logic is_signed(input muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    endfunction

    function automatic int unsigned op_iters(input muldiv_op_t op, input logic word,
                                             input int unsigned xlen, input int unsigned mul_bits);
        int unsigned width;
        width = word ? WORD_BITS : xlen;
        return is_div(op) ? width : width / mul_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Brief    : One combinational radix-2 restoring divide step.
// Revision : 1.0  initial release
// ============================================================================
module div_step #(
    parameter int W = 64
) (
    input  logic [W-1:0] rem,
    input  logic         dividend_msb,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);
    logic [W:0] shifted;
    logic [W:0] diff;

    assign shifted  = {rem, dividend_msb};
    assign diff     = shifted - {1'b0, divisor};
    // No borrow out of the top bit means the divisor fits.
    assign q_bit    = ~diff[W];
    assign rem_next = q_bit ? diff[W-1:0] : shifted[W-1:0];
endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Multi-cycle RV64M/RV32M multiply/divide with ready/valid and tag.
//            Optional MULDIV_EARLY_OUT_EN skips iteration for trivial operands.
// Revision : 1.0  initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int MUL_BITS = 4,
    parameter int TAG_W    = 6
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_result,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_dbz
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic sgn);
        logic [XLEN-1:0] r;
        r = v;
        for (int i = 32; i < XLEN; i++) r[i] = sgn & v[31];
        return r;
    endfunction

    logic [1:0]        state;
    logic [CW-1:0]     cnt, last;
    muldiv_op_t        op_in;
    logic              accept, word_in, div_in, a_sgn, b_sgn, a_neg, b_neg;
    logic              dbz_in, ovf_in, neg_in, skip;
    logic [XLEN-1:0]   a_eff, b_eff, a_mag, b_mag;
    logic              op_div, op_rem, op_hi, op_word, neg_r, dbz_r, ovf_r;
    logic [XLEN-1:0]   a_orig, part_rem, quo, dsor, mplier, step_rem;
    logic              step_q;
    logic [2*XLEN-1:0] acc, mcand, acc_next, prod_s;
    logic [XLEN-1:0]   q_s, r_s, raw, result;

    assign op_in      = muldiv_op_t'(req_op);
    assign req_ready  = ~flush & ((state == S_IDLE) | ((state == S_DONE) & resp_ready));
    assign accept     = req_valid & req_ready;
    assign resp_valid = (state == S_DONE);

    // Word ops only exist for XLEN=64; on RV32 they decode as their full-width twins.
    assign word_in = (XLEN == 64) && is_word(op_in);
    assign div_in  = is_div(op_in);
    assign a_sgn   = is_signed(op_in);
    assign b_sgn   = is_signed(op_in) && (op_in != OP_MULHSU);
    assign a_eff   = word_in ? ext32(req_a, a_sgn) : req_a;
    assign b_eff   = word_in ? ext32(req_b, b_sgn) : req_b;
    assign a_neg   = a_sgn & a_eff[XLEN-1];
    assign b_neg   = b_sgn & b_eff[XLEN-1];
    assign a_mag   = a_neg ? -a_eff : a_eff;
    assign b_mag   = b_neg ? -b_eff : b_eff;
    assign dbz_in  = (b_eff == '0);
    assign ovf_in  = div_in & a_sgn & (b_eff == '1) &
                     (word_in ? (a_eff[31:0] == 32'h8000_0000) : (a_eff == MIN_NEG));
    assign neg_in  = (div_in && is_rem(op_in)) ? a_neg : (a_neg ^ b_neg);

`ifdef MULDIV_EARLY_OUT_EN
    assign skip = div_in ? (dbz_in | ovf_in) : ((a_eff == '0) | (b_eff == '0));
`else
    assign skip = 1'b0;
`endif

    div_step #(.W(XLEN)) u_div_step (
        .rem          (part_rem),
        .dividend_msb (quo[XLEN-1]),
        .divisor      (dsor),
        .rem_next     (step_rem),
        .q_bit        (step_q)
    );

    always_comb begin
        acc_next = acc;
        for (int i = 0; i < MUL_BITS; i++)
            if (mplier[i]) acc_next = acc_next + (mcand << i);
    end

    always_comb begin
        prod_s = neg_r ? -acc : acc;
        q_s    = neg_r ? -quo : quo;
        r_s    = neg_r ? -part_rem : part_rem;
        if (op_div) begin
            if (dbz_r)      raw = op_rem ? a_orig : '1;
            else if (ovf_r) raw = op_rem ? '0 : a_orig;
            else            raw = op_rem ? r_s : q_s;
        end else begin
            raw = op_hi ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        end
        result = op_word ? ext32(raw, 1'b1) : raw;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            last        <= '0;
            op_div      <= 1'b0;
            op_rem      <= 1'b0;
            op_hi       <= 1'b0;
            op_word     <= 1'b0;
            neg_r       <= 1'b0;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
            a_orig      <= '0;
            part_rem    <= '0;
            quo         <= '0;
            dsor        <= '0;
            mplier      <= '0;
            acc         <= '0;
            mcand       <= '0;
            resp_result <= '0;
            resp_tag    <= '0;
            resp_dbz    <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
        end else if (accept) begin
            state    <= skip ? S_FIXUP : S_BUSY;
            cnt      <= '0;
            last     <= CW'(op_iters(op_in, word_in, XLEN, MUL_BITS) - 1);
            op_div   <= div_in;
            op_rem   <= is_rem(op_in);
            op_hi    <= is_mul_high(op_in);
            op_word  <= word_in;
            neg_r    <= neg_in;
            dbz_r    <= dbz_in;
            ovf_r    <= ovf_in;
            a_orig   <= a_eff;
            part_rem <= '0;
            // Word dividends are pre-aligned so their bit 31 is consumed first.
            quo      <= a_mag << (word_in ? XLEN - 32 : 0);
            dsor     <= b_mag;
            acc      <= '0;
            mcand    <= {{XLEN{1'b0}}, a_mag};
            mplier   <= b_mag;
            resp_tag <= req_tag;
        end else begin
            case (state)
                S_BUSY: begin
                    if (op_div) begin
                        part_rem <= step_rem;
                        quo      <= {quo[XLEN-2:0], step_q};
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand << MUL_BITS;
                        mplier <= mplier >> MUL_BITS;
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == last) state <= S_FIXUP;
                end
                S_FIXUP: begin
                    resp_result <= result;
                    resp_dbz    <= op_div & dbz_r;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    if (resp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
